// File: rtl/input_sync_debounce.sv
// Synchronizes async_in into clk and accepts a new level once it persists for DEBOUNCE_CYCLES enabled cycles.
// Step-to-s_out latency is SYNC_STAGES+DEBOUNCE_CYCLES edges. There is no backpressure, and all outputs are registered.
module input_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                async_in,
  input  logic                enable,
  input  logic                clear_glitch,
  output logic                s_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int                  CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   differ;
  logic                   accept;
  logic                   glitch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

  // A glitch is a pending transition abandoned before it reached the accept threshold.
  always_comb begin
    differ  = (s_sync != s_out);
    accept  = enable && differ && (cnt == CNT_LAST);
    glitch  = enable && !differ && (cnt != '0);
    cnt_nxt = cnt;
    if (!enable || !differ || accept) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      s_out      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      rise_pulse <= accept && s_sync;
      fall_pulse <= accept && !s_sync;
      if (accept) begin
        s_out <= s_sync;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      glitch_count <= '0;
    end else if (clear_glitch) begin
      glitch_count <= '0;
    end else if (glitch && (glitch_count != GLITCH_MAX)) begin
      glitch_count <= glitch_count + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Directed and random stimulus for input_sync_debounce, checked against a run-length reference model.
// A second instance with a 2-bit glitch counter observes saturation.
module tb_input_sync_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk;
  logic       resetn;
  logic       async_in;
  logic       enable;
  logic       clear_glitch;
  logic       s_out, rise_pulse, fall_pulse;
  logic [7:0] glitch_count;
  logic       s_out2, rise2, fall2;
  logic [1:0] glitch_count2;

  input_sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .GLITCH_W(8)) dut (
    .clk(clk), .resetn(resetn), .async_in(async_in), .enable(enable),
    .clear_glitch(clear_glitch), .s_out(s_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .glitch_count(glitch_count)
  );

  input_sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .GLITCH_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .async_in(async_in), .enable(enable),
    .clear_glitch(clear_glitch), .s_out(s_out2), .rise_pulse(rise2),
    .fall_pulse(fall2), .glitch_count(glitch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  int rises  = 0;
  int falls  = 0;

  // Reference model: samples reach the filter SYNC edges late. The filter accepts a level
  // after DEB consecutive enabled differing samples.
  bit q[$];
  bit m_out, m_rise, m_fall;
  int m_run;
  int m_glitches;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
    m_out = 0; m_rise = 0; m_fall = 0; m_run = 0; m_glitches = 0;
  endtask

  task automatic model_edge(bit a, bit en, bit clr);
    bit seen;
    seen = q.pop_front();
    q.push_back(a);
    m_rise = 0;
    m_fall = 0;
    if (!en) begin
      m_run = 0;
    end else if (seen == m_out) begin
      if (m_run > 0) m_glitches++;
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_out  = seen;
        m_rise = seen;
        m_fall = !seen;
        m_run  = 0;
      end
    end
    if (clr) m_glitches = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  task automatic check_all();
    chk("s_out", 32'(s_out), 32'(m_out));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("pulse_exclusive", 32'(rise_pulse & fall_pulse), 0);
    chk("glitch_count", 32'(glitch_count), (m_glitches > 255) ? 255 : m_glitches);
    chk("s_out_w2", 32'(s_out2), 32'(m_out));
    chk("glitch_count_w2", 32'(glitch_count2), (m_glitches > 3) ? 3 : m_glitches);
  endtask

  // Inputs are changed 1ns after an edge and hold until the next one.
  task automatic cyc(bit a, bit en, bit clr);
    async_in     = a;
    enable       = en;
    clear_glitch = clr;
    @(posedge clk);
    edge_n++;
    model_edge(a, en, clr);
    #1;
    rises += int'(rise_pulse);
    falls += int'(fall_pulse);
    check_all();
  endtask

  task automatic glitch2(bit clr_on_detect);
    cyc(1, 1, 0); cyc(1, 1, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(0, 1, clr_on_detect);
    repeat (7) cyc(0, 1, 0);
  endtask

  initial begin
    int first;
    int cap;
    bit lvl;
    int seg;

    resetn = 1'b0; async_in = 1'b0; enable = 1'b1; clear_glitch = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    resetn = 1'b1;

    // Step response
    repeat (10) cyc(0, 1, 0);
    cap = edge_n + 1;
    first = -1;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0);
      if (first < 0 && s_out === 1'b1) first = edge_n;
    end
    chk("step_edges_incl_capture", first - cap + 1, SYNC + DEB);
    chk("step_rise_count", rises, 1);
    chk("step_glitch", 32'(glitch_count), 0);
    repeat (12) cyc(0, 1, 0);

    // Glitch rejection
    rises = 0; falls = 0;
    repeat (3) glitch2(0);
    chk("glitch_three", 32'(glitch_count), 3);
    chk("glitch_no_pulses", rises + falls, 0);

    // Saturation, then clear coinciding with a detected glitch
    repeat (5) glitch2(0);
    chk("sat_w2", 32'(glitch_count2), 3);
    chk("sat_w8", 32'(glitch_count), 8);
    glitch2(1);
    chk("clear_wins_w2", 32'(glitch_count2), 0);
    chk("clear_wins_w8", 32'(glitch_count), 0);

    // Enable freeze
    repeat (20) cyc(1, 0, 0);
    chk("frozen_low", 32'(s_out), 0);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1, 0);
      if (first < 0 && s_out === 1'b1) first = i;
    end
    chk("reenable_edges", first, DEB);
    chk("reenable_glitch", 32'(glitch_count), 0);
    repeat (12) cyc(0, 1, 0);

    // Reset in the middle of a pending transition (two samples into it)
    repeat (4) cyc(1, 1, 0);
    #3 resetn = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    resetn = 1'b1;
    first = -1;
    rises = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1, 0);
      if (first < 0 && s_out === 1'b1) first = i;
    end
    chk("rst_release_edges", first, SYNC + DEB);
    chk("rst_release_rises", rises, 1);
    repeat (12) cyc(0, 1, 0);

    // Chained with a downstream edge counter, with 1-cycle glitches in each low gap
    rises = 0; falls = 0;
    repeat (5) begin
      repeat (8) cyc(1, 1, 0);
      repeat (3) cyc(0, 1, 0);
      cyc(1, 1, 0);
      repeat (4) cyc(0, 1, 0);
    end
    repeat (16) cyc(0, 1, 0);
    chk("chain_rises", rises, 5);
    chk("chain_falls", falls, 5);

    // Random segments, with enable and clear randomized per cycle
    lvl = 0;
    for (int n = 0; n < 160; n++) begin
      lvl = !lvl;
      seg = $urandom_range(1, 7);
      for (int k = 0; k < seg; k++)
        cyc(lvl, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
